// File: rtl/message_scroller.sv
// message_scroller: sliding four-character window over a scrolling message for the LED driver.
// Optional `MSG_LOAD_EN adds a write port (wr_en/wr_addr/wr_data) so the message can be changed at run time.
module message_scroller #(
  parameter int MSG_LEN       = 16,
  parameter int SCROLL_CYCLES = 1_000_000,
  parameter int PTR_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_btn,
  input  logic             pause,
  output logic [3:0]       char3,
  output logic [3:0]       char2,
  output logic [3:0]       char1,
  output logic [3:0]       char0,
  output logic [PTR_W-1:0] ptr,
  output logic             wrap
`ifdef MSG_LOAD_EN
  ,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [3:0]       wr_data
`endif
);
  localparam int               CNT_W   = $clog2(SCROLL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCROLL_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(MSG_LEN - 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_q;
  logic [3:0]       w_msg [MSG_LEN];
  logic             w_step_adv;
  logic             w_auto_adv;
  logic             w_adv;
  assign w_step_adv = step_btn & ~r_btn_q;
  assign w_auto_adv = ~pause & (r_cnt == CNT_MAX);
  assign w_adv      = w_step_adv | w_auto_adv;
`ifdef MSG_LOAD_EN
  logic [3:0] r_msg [MSG_LEN];
  // Writable message store, reloaded with the default 0..F pattern on reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < MSG_LEN; i++) r_msg[i] <= 4'(i);
    else if (wr_en) r_msg[wr_addr] <= wr_data;
  // Window reads come from the stored message
  always_comb for (int i = 0; i < MSG_LEN; i++) w_msg[i] = r_msg[i];
`else
  // Fixed message: code i at index i, folds to constants
  always_comb for (int i = 0; i < MSG_LEN; i++) w_msg[i] = 4'(i);
`endif
  // Tick counter, button edge detect, window pointer, wrap pulse and registered window
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt   <= '0;
      r_btn_q <= 1'b0;
      ptr     <= '0;
      wrap    <= 1'b0;
      char3   <= 4'd0;
      char2   <= 4'd1;
      char1   <= 4'd2;
      char0   <= 4'd3;
    end else begin
      r_btn_q <= step_btn;
      r_cnt   <= w_adv ? '0 : pause ? r_cnt : r_cnt + 1'b1;
      ptr     <= w_adv ? ptr + 1'b1 : ptr;
      wrap    <= w_adv & (ptr == PTR_MAX);
      char3   <= w_msg[ptr];
      char2   <= w_msg[ptr + PTR_W'(1)];
      char1   <= w_msg[ptr + PTR_W'(2)];
      char0   <= w_msg[ptr + PTR_W'(3)];
    end
endmodule
